// File: rtl/csr_pkg.sv
// Shared types and constants for the machine-mode CSR commit unit:
// CSR addresses, mstatus field positions, FSM states and channel packets.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET = 12'hB02;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic {IDLE, REDIR} state_t;

  // Packet from writeback; no flag set means a plain CSR write.
  typedef struct packed {
    logic        ecall;
    logic        ebreak;
    logic        mret;
    logic [63:0] pc;
    logic        csr_write_enable;
    logic [11:0] csr_dest_addr;
    logic [63:0] csr_write_data;
  } csr_writer_t;

  typedef struct packed {
    logic        do_jump;
    logic        jump_inst;
    logic [63:0] dest_addr;
    logic [31:0] inst_counter;
  } jump_writer_t;

endpackage

// File: rtl/csr_counters.sv
// mcycle / minstret performance counters; a same-cycle explicit write
// overrides the increment. Only instantiated when CSR_COUNTERS_EN is defined.
module csr_counters
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        retire,
  input  logic        wr_en,
  input  logic [11:0] wr_addr,
  input  logic [63:0] wr_data,
  output logic [63:0] mcycle,
  output logic [63:0] minstret
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (wr_en && wr_addr == CSR_MCYCLE) mcycle <= wr_data;
      else                                mcycle <= mcycle + 64'd1;

      if (wr_en && wr_addr == CSR_MINSTRET) minstret <= wr_data;
      else if (retire)                      minstret <= minstret + 64'd1;
    end
  end

endmodule

// File: rtl/csr_commit_unit.sv
// Machine-mode CSR file and commit point for csr_writer packets; traps and mret
// produce a one-cycle redirect. Optional counters under `define CSR_COUNTERS_EN.
module csr_commit_unit
  import csr_pkg::*;
#(
  parameter logic [63:0] MTVEC_RESET  = 64'h0,
  parameter logic [63:0] MCAUSE_ECALL = 64'd11,
  parameter logic [63:0] MCAUSE_EBRK  = 64'd3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_valid,
  input  csr_writer_t  wr,
  output logic         wr_ready,
  input  logic         retire,
  input  logic [11:0]  rd_addr,
  output logic [63:0]  rd_data,
  output jump_writer_t redirect
);

  state_t      state_q, state_d;
  logic [63:0] target_q;
  logic [63:0] mstatus, mepc, mcause, mscratch, mie, mip, mtvec;
  logic        accept, is_ecall, is_ebreak, is_mret, is_plain, plain_we;

  assign wr_ready  = (state_q == IDLE);
  assign accept    = wr_valid & wr_ready;
  assign is_ecall  = wr.ecall;
  assign is_ebreak = ~wr.ecall & wr.ebreak;
  assign is_mret   = ~wr.ecall & ~wr.ebreak & wr.mret;
  assign is_plain  = ~wr.ecall & ~wr.ebreak & ~wr.mret;
  assign plain_we  = accept & is_plain & wr.csr_write_enable;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    redirect = '0;
    case (state_q)
      IDLE: begin
        if (accept && !is_plain) state_d = REDIR;
      end
      REDIR: begin
        redirect.do_jump      = 1'b1;
        redirect.jump_inst    = 1'b1;
        redirect.dest_addr    = target_q;
        redirect.inst_counter = '0;
        state_d               = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every CSR update in this block sees the
  // pre-edge values (mret reads the old mepc, ecall reads the old MIE).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mstatus  <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mscratch <= '0;
      mie      <= '0;
      mip      <= '0;
      mtvec    <= MTVEC_RESET;
      target_q <= '0;
    end else if (accept) begin
      if (is_ecall || is_ebreak) begin
        mepc                                  <= wr.pc;
        mcause                                <= is_ecall ? MCAUSE_ECALL : MCAUSE_EBRK;
        mstatus[MSTATUS_MPIE]                 <= mstatus[MSTATUS_MIE];
        mstatus[MSTATUS_MIE]                  <= 1'b0;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
        target_q                              <= {mtvec[63:2], 2'b00};
      end else if (is_mret) begin
        mstatus[MSTATUS_MIE]                  <= mstatus[MSTATUS_MPIE];
        mstatus[MSTATUS_MPIE]                 <= 1'b1;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b00;
        target_q                              <= mepc;
      end else if (wr.csr_write_enable) begin
        case (wr.csr_dest_addr)
          CSR_MSTATUS:  mstatus  <= wr.csr_write_data;
          CSR_MIE:      mie      <= wr.csr_write_data;
          CSR_MTVEC:    mtvec    <= wr.csr_write_data;
          CSR_MSCRATCH: mscratch <= wr.csr_write_data;
          CSR_MEPC:     mepc     <= wr.csr_write_data;
          CSR_MCAUSE:   mcause   <= wr.csr_write_data;
          CSR_MIP:      mip      <= wr.csr_write_data;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;

  csr_counters u_counters (
    .clk      (clk),
    .reset    (reset),
    .retire   (retire),
    .wr_en    (plain_we),
    .wr_addr  (wr.csr_dest_addr),
    .wr_data  (wr.csr_write_data),
    .mcycle   (mcycle),
    .minstret (minstret)
  );
`else
  logic unused_counter_inputs;
  assign unused_counter_inputs = retire ^ plain_we;
`endif

  // Registered values only: a read in the same cycle as a write returns the old value.
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CSR_MSTATUS:  rd_data = mstatus;
      CSR_MIE:      rd_data = mie;
      CSR_MTVEC:    rd_data = mtvec;
      CSR_MSCRATCH: rd_data = mscratch;
      CSR_MEPC:     rd_data = mepc;
      CSR_MCAUSE:   rd_data = mcause;
      CSR_MIP:      rd_data = mip;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:   rd_data = mcycle;
      CSR_MINSTRET: rd_data = minstret;
`endif
      default:      rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_csr_commit_unit.sv
// Directed self-checking bench for csr_commit_unit (default parameters);
// counter expectations follow whether CSR_COUNTERS_EN is defined.
module tb_csr_commit_unit;
  import csr_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         wr_valid;
  csr_writer_t  wr;
  logic         wr_ready;
  logic         retire;
  logic [11:0]  rd_addr;
  logic [63:0]  rd_data;
  jump_writer_t redirect;

  int total = 0;
  int bad   = 0;

  csr_commit_unit dut (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr       (wr),
    .wr_ready (wr_ready),
    .retire   (retire),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .redirect (redirect)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_csr(input logic [11:0] addr, output logic [63:0] data);
    rd_addr = addr;
    #1;
    data = rd_data;
  endtask

  function automatic csr_writer_t plain(input logic we, input logic [11:0] addr,
                                        input logic [63:0] data);
    csr_writer_t p;
    p = '0;
    p.csr_write_enable = we;
    p.csr_dest_addr    = addr;
    p.csr_write_data   = data;
    return p;
  endfunction

  function automatic csr_writer_t trap(input logic ec, input logic eb, input logic mr,
                                       input logic [63:0] pc);
    csr_writer_t p;
    p = '0;
    p.ecall  = ec;
    p.ebreak = eb;
    p.mret   = mr;
    p.pc     = pc;
    return p;
  endfunction

  task automatic send(input csr_writer_t p);
    wr = p;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic expect_csr(input string name, input logic [11:0] addr,
                            input logic [63:0] exp);
    logic [63:0] got;
    read_csr(addr, got);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic expect_bit(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, got, exp);
    end
  endtask

  task automatic expect_redirect(input string name, input logic [63:0] dest);
    total++;
    if (redirect.do_jump !== 1'b1 || redirect.jump_inst !== 1'b1 ||
        redirect.dest_addr !== dest || redirect.inst_counter !== 32'd0 ||
        wr_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s: do_jump=%b jump_inst=%b dest=%h cnt=%0d ready=%b want dest=%h",
               name, redirect.do_jump, redirect.jump_inst, redirect.dest_addr,
               redirect.inst_counter, wr_ready, dest);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_valid = 1'b0; wr = '0; retire = 1'b0; rd_addr = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    expect_csr("reset_mtvec", CSR_MTVEC, 64'h0);
    expect_csr("reset_mstatus", CSR_MSTATUS, 64'h0);
    expect_bit("reset_do_jump", redirect.do_jump, 1'b0);
    expect_bit("reset_wr_ready", wr_ready, 1'b1);
  endtask

  task automatic test_plain_write();
    wr = plain(1'b1, CSR_MSCRATCH, 64'hDEAD_BEEF);
    wr_valid = 1'b1;
    expect_csr("plain_same_cycle_old", CSR_MSCRATCH, 64'h0);
    tick();
    wr_valid = 1'b0;
    expect_csr("plain_mscratch", CSR_MSCRATCH, 64'hDEAD_BEEF);
    send(plain(1'b0, CSR_MSCRATCH, 64'h1234));
    expect_csr("plain_we0_nochange", CSR_MSCRATCH, 64'hDEAD_BEEF);
    send(plain(1'b1, 12'h7C0, 64'h55));
    expect_csr("plain_unimpl_reads0", 12'h7C0, 64'h0);
    expect_bit("plain_no_jump", redirect.do_jump, 1'b0);
  endtask

  task automatic test_ecall();
    send(plain(1'b1, CSR_MTVEC, 64'h8000_0101));
    send(plain(1'b1, CSR_MSTATUS, 64'h8));
    send(trap(1'b1, 1'b0, 1'b0, 64'h8000_0040));
    expect_redirect("ecall_redirect", 64'h8000_0100);
    expect_csr("ecall_mepc", CSR_MEPC, 64'h8000_0040);
    expect_csr("ecall_mcause", CSR_MCAUSE, 64'd11);
    expect_csr("ecall_mstatus", CSR_MSTATUS, 64'h1880);
    tick();
    expect_bit("ecall_jump_one_cycle", redirect.do_jump, 1'b0);
    expect_bit("ecall_ready_back", wr_ready, 1'b1);
  endtask

  task automatic test_mret();
    send(plain(1'b1, CSR_MEPC, 64'h8000_0044));
    send(trap(1'b0, 1'b0, 1'b1, 64'h0));
    expect_redirect("mret_redirect", 64'h8000_0044);
    expect_csr("mret_mstatus", CSR_MSTATUS, 64'h88);
    tick();
    expect_bit("mret_jump_one_cycle", redirect.do_jump, 1'b0);
  endtask

  task automatic test_priority_and_hold();
    send(trap(1'b1, 1'b0, 1'b1, 64'h1230));
    expect_redirect("prio_redirect", 64'h8000_0100);
    expect_csr("prio_mcause", CSR_MCAUSE, 64'd11);
    expect_csr("prio_mstatus", CSR_MSTATUS, 64'h1880);
    // Offer an ebreak during REDIR; it must be ignored.
    wr = trap(1'b0, 1'b1, 1'b0, 64'h5550);
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    expect_csr("hold_mepc", CSR_MEPC, 64'h1230);
    expect_csr("hold_mcause", CSR_MCAUSE, 64'd11);
    expect_bit("hold_no_jump", redirect.do_jump, 1'b0);
  endtask

  task automatic test_ebreak();
    send(trap(1'b0, 1'b1, 1'b1, 64'h2000));
    expect_redirect("ebreak_redirect", 64'h8000_0100);
    expect_csr("ebreak_mcause", CSR_MCAUSE, 64'd3);
    expect_csr("ebreak_mepc", CSR_MEPC, 64'h2000);
    expect_csr("ebreak_mstatus", CSR_MSTATUS, 64'h1800);
    tick();
  endtask

  task automatic test_reset_mid_redir();
    send(trap(1'b1, 1'b0, 1'b0, 64'h3000));
    expect_bit("midrst_jump_before", redirect.do_jump, 1'b1);
    reset = 1'b1;
    #1;
    expect_bit("midrst_jump_cleared", redirect.do_jump, 1'b0);
    expect_bit("midrst_ready", wr_ready, 1'b1);
    tick();
    reset = 1'b0;
    tick();
    expect_csr("midrst_mepc", CSR_MEPC, 64'h0);
    expect_csr("midrst_mtvec", CSR_MTVEC, 64'h0);
    expect_csr("midrst_mscratch", CSR_MSCRATCH, 64'h0);
  endtask

  task automatic test_counters();
`ifdef CSR_COUNTERS_EN
    send(plain(1'b1, CSR_MCYCLE, 64'h0));
    expect_csr("cnt_mcycle_written0", CSR_MCYCLE, 64'h0);
    repeat (10) tick();
    expect_csr("cnt_mcycle_10", CSR_MCYCLE, 64'd10);
    retire = 1'b1;
    send(plain(1'b1, CSR_MINSTRET, 64'h0));
    retire = 1'b0;
    expect_csr("cnt_minstret_write_wins", CSR_MINSTRET, 64'h0);
    retire = 1'b1;
    repeat (4) tick();
    retire = 1'b0;
    tick();
    expect_csr("cnt_minstret_4", CSR_MINSTRET, 64'd4);
    send(plain(1'b1, CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF));
    expect_csr("cnt_mcycle_allones", CSR_MCYCLE, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    expect_csr("cnt_mcycle_wrap", CSR_MCYCLE, 64'h0);
`else
    retire = 1'b1;
    send(plain(1'b1, CSR_MCYCLE, 64'h77));
    repeat (3) tick();
    retire = 1'b0;
    expect_csr("nocnt_mcycle_0", CSR_MCYCLE, 64'h0);
    expect_csr("nocnt_minstret_0", CSR_MINSTRET, 64'h0);
`endif
  endtask

  initial begin
    test_reset();
    test_plain_write();
    test_ecall();
    test_mret();
    test_priority_and_hold();
    test_ebreak();
    test_reset_mid_redir();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
